// File: rtl/fifo_sync.sv
// ---------------------------------------------------------------------------
// fifo_sync
//   Single-clock synchronous FIFO that buffers small codes from the input
//   stage and presents each popped entry on a registered output feeding the
//   3-bit seven-segment decoder. Occupancy and full/empty flags are exported
//   for LEDs.
//
// Parameters
//   DW     data width in bits (3 matches the decoder input)
//   DEPTH  number of entries; power of two, at least 2
//   AW     pointer width, derived from DEPTH (not meant to be overridden)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, highest priority
//   wr_en     push request
//   din       push data
//   rd_en     pop request
//   dout      popped data, registered, held between accepted pops
//   rd_valid  one-cycle pulse the cycle after a pop is accepted
//   full      count == DEPTH
//   empty     count == 0
//   count     current occupancy, 0..DEPTH
//
// Optional build macro FIFO_ERR_EN adds two sticky error outputs:
//   ovf       set on wr_en while full, cleared only by rst
//   udf       set on rd_en while empty, cleared only by rst
// ---------------------------------------------------------------------------
module fifo_sync #(
    parameter  int DW    = 3,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
`ifdef FIFO_ERR_EN
    ,
    output logic          ovf,
    output logic          udf
`endif
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance is qualified by the registered flags, so a write while full
    // is dropped even when a read frees a slot in the same cycle.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because empty is forced high, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                // Power-of-two depth: truncation to AW bits is the wrap.
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            rd_valid <= rd_acc;
            count    <= count_next;
            // Flags come from the next count so they always agree with count.
            empty    <= (count_next == '0);
            full     <= (count_next == FULL_COUNT);
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            if (rd_en && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule
